w5500_spi_slave: RTL and testbench
==================================

Name: w5500_spi_slave

Overview:
- SPI mode-0 responder that decodes W5500-style frames: 16-bit address, then a control byte, then N data bytes.
- Bench/loopback counterpart to the existing spi_master/spi_control initiator path.
- Oversamples cs/sck/din on the system clock.
- Converts each frame into single-byte register-file read/write strobes with auto-incrementing address.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for cs/sck/din (minimum 2).
- ADDR_W, 16, frame address width.
- BSB_W, 5, block-select field width.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; asynchronous assert, active-low.
- cs  input  1  chip select from master, active-low.
- sck  input  1  SPI clock from master, idle low (mode 0).
- din  input  1  MOSI, MSB first.
- dout  output  1  MISO, MSB first; registered.
- reg_addr  output  ADDR_W  current byte address.
- reg_bsb  output  BSB_W  block select, taken from control byte bits [7:3].
- reg_wr  output  1  one-cycle write strobe.
- reg_wdata  output  8  write data; valid while reg_wr is high.
- reg_rd  output  1  one-cycle read request.
- reg_rdata  input  8  read data; sampled exactly 1 clk after reg_rd.
- frame_active  output  1  high from cs fall (synchronized) until cs rise.
- frame_err  output  1  one-cycle pulse on aborted frame.

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, state IDLE, counters 0.
- Timing constraint: sck high and low phases are each at least SYNC_STAGES+4 clk periods. Faster sck is unsupported.
- Edge detection: E = the clk cycle in which the synchronized sck rising edge is detected; F = same for the falling edge.
- On each E: shift din into rx_sr and increment bit_cnt (3 bits, wraps 7 to 0).
- On each F: shift tx_sr and drive dout = tx_sr[7].
- State IDLE: on synchronized cs fall, go to ADDR_H; frame_active=1.
- State ADDR_H: after 8 bits, latch reg_addr[15:8]; go to ADDR_L.
- State ADDR_L: after 8 bits, latch reg_addr[7:0]; go to CTRL.
- State CTRL: after 8 bits, latch bsb=[7:3], rwb=[2], om=[1:0]; byte_cnt=0; go to DATA.
- Opcode mode om: 00 = variable length, until cs rises; 01/10/11 = 1/2/4 data bytes.
- State DATA, write (rwb=1), at the 8th E of each byte:
  - cycle E+1: reg_wdata=rx_sr and reg_wr=1, with reg_addr = that byte's address.
  - cycle E+2: reg_addr increments.
- State DATA, read (rwb=0):
  - First byte: reg_rd pulses in cycle E+1 after the CTRL byte completes.
  - At E+2, tx_sr=reg_rdata and dout=reg_rdata[7]. The master samples this bit at the next rising edge.
  - At the 8th E of each read byte: reg_addr increments in E+1; reg_rd pulses in E+2 (prefetch); tx_sr loads in E+3.
  - Prefetch occurs in variable mode even if cs then rises; this is harmless.
- Fixed-length overrun: bytes beyond the om count produce no reg_wr/reg_rd, no address increment, and dout=0.
- Address arithmetic: reg_addr is modulo 2^ADDR_W, so 0xFFFF increments to 0x0000.
- cs rise (synchronized), any state: go to IDLE; frame_active=0; dout=0.
  - frame_err pulses 1 cycle if the state was ADDR_H/ADDR_L/CTRL or bit_cnt≠0.
  - A partial byte is discarded and produces no strobe.
- Simultaneous E and cs rise in the same cycle: cs rise wins and the bit is discarded.
- cs high: dout=0 (no tristate); sck edges are ignored.

Optional Feature:
- Macro: W5500_PHASE_ECHO_EN.
- Defined: tx_sr preloads 0x01, 0x02, 0x03 for ADDR_H, ADDR_L, CTRL respectively, loaded at the cs fall and at the 8th E of the preceding byte. dout shifts these values out, matching W5500 behaviour.
- Undefined: dout=0 throughout the address/control phases.

Decomposition:
- Package w5500_spi_pkg contains:
  - state enum (IDLE, ADDR_H, ADDR_L, CTRL, DATA);
  - om encodings (OM_VDM=2'b00, OM_FDM1=2'b01, OM_FDM2=2'b10, OM_FDM4=2'b11);
  - RWB_WRITE=1'b1;
  - echo constants 8'h01/8'h02/8'h03.
- Sub-module spi_slv_sync: SYNC_STAGES synchronizers for cs/sck/din plus sck rise/fall and cs rise/fall pulse outputs.

Test Plan:
- Write, variable mode: frame 00 2E 04 01 00, then cs rise → reg_wr (0x002E,0x01), reg_wr (0x002F,0x00); frame_err=0.
- Read, 1-byte fixed mode: frame 00 39 09, model returns reg_rdata = addr[7:0], 2 data bytes clocked → MISO byte0=0x39, byte1=0x00; exactly one reg_rd; reg_bsb=1.
- Read, 4-byte fixed mode: frame at 0x0010 with ctrl 0x03 → MISO 0x10,0x11,0x12,0x13; 4 reg_rd pulses.
- Wrap: write frame at FF FF 04 with data AA BB → writes at 0xFFFF=0xAA and 0x0000=0xBB.
- Abort: cs rises after 12 address bits → frame_err pulse, no reg_wr/reg_rd, state IDLE. Next frame decodes correctly.
- Reset mid-DATA (rstn low for 3 clk): all outputs 0 immediately. The following frame works.
- With W5500_PHASE_ECHO_EN: MISO during the header reads 01 02 03. Without the macro: 00 00 00.

Source files
------------

// File: rtl/w5500_spi_pkg.sv
// w5500_spi_pkg: shared types and constants for the W5500-style SPI responder.
//   state_t    - frame decoder states
//   OM_*       - opcode-mode encodings of control byte bits [1:0]
//   RWB_WRITE  - value of control byte bit [2] that selects a write
//   ECHO_*     - phase bytes shifted out on MISO during the header when
//                W5500_PHASE_ECHO_EN is defined
//   om_len()   - data-byte count of a fixed-length opcode mode
package w5500_spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_H = 3'd1,
        ADDR_L = 3'd2,
        CTRL   = 3'd3,
        DATA   = 3'd4
    } state_t;

    localparam logic [1:0] OM_VDM  = 2'b00;
    localparam logic [1:0] OM_FDM1 = 2'b01;
    localparam logic [1:0] OM_FDM2 = 2'b10;
    localparam logic [1:0] OM_FDM4 = 2'b11;

    localparam logic RWB_WRITE = 1'b1;

    localparam logic [7:0] ECHO_ADDR_H = 8'h01;
    localparam logic [7:0] ECHO_ADDR_L = 8'h02;
    localparam logic [7:0] ECHO_CTRL   = 8'h03;

    // Number of data bytes in a fixed-length mode; variable mode returns 0
    // and is handled separately by the caller.
    function automatic logic [2:0] om_len(input logic [1:0] om);
        logic [2:0] len;
        case (om)
            OM_FDM1: len = 3'd1;
            OM_FDM2: len = 3'd2;
            OM_FDM4: len = 3'd4;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// spi_slv_sync: input synchronizers for the SPI pins plus edge strobes.
//   clk, rstn          - system clock, async active-low reset
//   cs, sck, din       - raw SPI pins
//   din_s              - synchronized MOSI level
//   sck_rise, sck_fall - one-cycle pulses on synchronized sck edges
//   cs_rise, cs_fall   - one-cycle pulses on synchronized cs edges
// All three pins pass through the same number of stages so that an sck edge
// and a cs edge applied together are seen in the same clk cycle.
module spi_slv_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic cs,
    input  logic sck,
    input  logic din,
    output logic din_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] cs_q_r;
    logic [SYNC_STAGES-1:0] sck_q_r;
    logic [SYNC_STAGES-1:0] din_q_r;
    logic                   cs_prev_r;
    logic                   sck_prev_r;

    // Synchronizer chains plus one history flop per edge source; cs idles high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_q_r     <= {SYNC_STAGES{1'b1}};
            sck_q_r    <= {SYNC_STAGES{1'b0}};
            din_q_r    <= {SYNC_STAGES{1'b0}};
            cs_prev_r  <= 1'b1;
            sck_prev_r <= 1'b0;
        end else begin
            cs_q_r     <= {cs_q_r[SYNC_STAGES-2:0], cs};
            sck_q_r    <= {sck_q_r[SYNC_STAGES-2:0], sck};
            din_q_r    <= {din_q_r[SYNC_STAGES-2:0], din};
            cs_prev_r  <= cs_q_r[SYNC_STAGES-1];
            sck_prev_r <= sck_q_r[SYNC_STAGES-1];
        end
    end

    assign din_s    = din_q_r[SYNC_STAGES-1];
    assign sck_rise = sck_q_r[SYNC_STAGES-1] & ~sck_prev_r;
    assign sck_fall = ~sck_q_r[SYNC_STAGES-1] & sck_prev_r;
    assign cs_rise  = cs_q_r[SYNC_STAGES-1] & ~cs_prev_r;
    assign cs_fall  = ~cs_q_r[SYNC_STAGES-1] & cs_prev_r;

endmodule

// File: rtl/w5500_spi_slave.sv
// w5500_spi_slave: SPI mode-0 responder for W5500-style frames
// (16-bit address, control byte, data bytes) that turns each data byte into a
// single-cycle register-file write or read strobe with auto-increment.
//   clk, rstn              - system clock, async active-low reset
//   cs, sck, din           - SPI from the master (cs active-low, sck idles low)
//   dout                   - registered MISO, MSB first, 0 while cs is high
//   reg_addr, reg_bsb      - current byte address and block select
//   reg_wr, reg_wdata      - one-cycle write strobe and its data
//   reg_rd, reg_rdata      - one-cycle read request; reg_rdata is captured on
//                            the clk edge that ends the reg_rd cycle
//   frame_active           - high while a frame is open
//   frame_err              - one-cycle pulse when a frame is aborted
// Optional: define W5500_PHASE_ECHO_EN to shift 01/02/03 out during the header.
// ADDR_W must be at least 8.
module w5500_spi_slave
    import w5500_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 16,
    parameter int BSB_W       = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic              sck,
    input  logic              din,
    output logic              dout,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [BSB_W-1:0]  reg_bsb,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              frame_active,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic din_s, sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

    state_t              state_r, state_nxt_s;
    logic [2:0]          bit_cnt_r, byte_cnt_r;
    logic [6:0]          rx_sr_r;
    logic [7:0]          tx_sr_r, rx_byte_s, wdata_r, echo_val_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [BSB_W-1:0]    bsb_r;
    logic [1:0]          om_r;
    logic                rwb_r, dout_r, reg_wr_r, reg_rd_r, rd_pend_r;
    logic                frame_active_r, frame_err_r;
    logic                active_s, bit_s, fall_s, byte_done_s, start_s;
    logic                in_range_s, more_s, wr_fire_s, rd_first_s, rd_next_s;
    logic                ld_echo_s, err_s;

    spi_slv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .cs       (cs),
        .sck      (sck),
        .din      (din),
        .din_s    (din_s),
        .sck_rise (sck_rise_s),
        .sck_fall (sck_fall_s),
        .cs_rise  (cs_rise_s),
        .cs_fall  (cs_fall_s)
    );

    // Byte as it will stand once the current rising-edge bit is shifted in
    assign rx_byte_s = {rx_sr_r, din_s};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: cs rise always returns to IDLE, otherwise advance per byte
    always_comb begin
        state_nxt_s = state_r;
        if (cs_rise_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = cs_fall_s   ? ADDR_H : IDLE;
                ADDR_H:  state_nxt_s = byte_done_s ? ADDR_L : ADDR_H;
                ADDR_L:  state_nxt_s = byte_done_s ? CTRL   : ADDR_L;
                CTRL:    state_nxt_s = byte_done_s ? DATA   : CTRL;
                DATA:    state_nxt_s = DATA;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Output decode: per-cycle strobes; cs rise masks a coincident sck edge
    always_comb begin
        active_s    = (state_r != IDLE) && !cs_rise_s;
        bit_s       = active_s && sck_rise_s;
        fall_s      = active_s && sck_fall_s;
        byte_done_s = bit_s && (bit_cnt_r == 3'd7);
        start_s     = cs_fall_s && (state_r == IDLE);
        in_range_s  = (om_r == OM_VDM) || (byte_cnt_r < om_len(om_r));
        more_s      = (om_r == OM_VDM) || ((byte_cnt_r + 3'd1) < om_len(om_r));
        wr_fire_s   = 1'b0;
        rd_first_s  = 1'b0;
        rd_next_s   = 1'b0;
        ld_echo_s   = 1'b0;
        echo_val_s  = 8'h00;
        case (state_r)
            ADDR_H: begin
`ifdef W5500_PHASE_ECHO_EN
                ld_echo_s  = byte_done_s;
                echo_val_s = ECHO_ADDR_L;
`endif
            end
            ADDR_L: begin
`ifdef W5500_PHASE_ECHO_EN
                ld_echo_s  = byte_done_s;
                echo_val_s = ECHO_CTRL;
`endif
            end
            CTRL: begin
                rd_first_s = byte_done_s && (rx_byte_s[2] != RWB_WRITE);
            end
            DATA: begin
                if (byte_done_s && (rwb_r == RWB_WRITE)) begin
                    wr_fire_s = in_range_s;
                end else if (byte_done_s) begin
                    rd_next_s = more_s;
                end else begin
                    wr_fire_s = 1'b0;
                end
            end
            default: begin
                ld_echo_s = 1'b0;
            end
        endcase
        if (cs_rise_s && ((state_r == ADDR_H) || (state_r == ADDR_L) ||
                          (state_r == CTRL) || (bit_cnt_r != 3'd0))) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Datapath: shifters, address/control latches, strobes and MISO.
    // Later assignments deliberately override earlier ones (cs rise last).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_r      <= 3'd0;
            byte_cnt_r     <= 3'd0;
            rx_sr_r        <= 7'd0;
            tx_sr_r        <= 8'h00;
            wdata_r        <= 8'h00;
            addr_r         <= {ADDR_W{1'b0}};
            bsb_r          <= {BSB_W{1'b0}};
            om_r           <= 2'b00;
            rwb_r          <= 1'b0;
            dout_r         <= 1'b0;
            reg_wr_r       <= 1'b0;
            reg_rd_r       <= 1'b0;
            rd_pend_r      <= 1'b0;
            frame_active_r <= 1'b0;
            frame_err_r    <= 1'b0;
        end else begin
            reg_wr_r       <= 1'b0;
            reg_rd_r       <= rd_pend_r;
            rd_pend_r      <= 1'b0;
            frame_err_r    <= err_s;
            frame_active_r <= (state_nxt_s != IDLE);
            if (start_s) begin
                bit_cnt_r  <= 3'd0;
                byte_cnt_r <= 3'd0;
`ifdef W5500_PHASE_ECHO_EN
                // No falling edge precedes the first bit, so present bit 7 now
                tx_sr_r    <= {ECHO_ADDR_H[6:0], 1'b0};
                dout_r     <= ECHO_ADDR_H[7];
`else
                tx_sr_r    <= 8'h00;
                dout_r     <= 1'b0;
`endif
            end
            if (bit_s) begin
                rx_sr_r   <= rx_byte_s[6:0];
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (fall_s) begin
                dout_r  <= tx_sr_r[7];
                tx_sr_r <= {tx_sr_r[6:0], 1'b0};
            end
            if (byte_done_s && (state_r == ADDR_H)) begin
                addr_r <= ADDR_W'({rx_byte_s, 8'h00});
            end
            if (byte_done_s && (state_r == ADDR_L)) begin
                addr_r[7:0] <= rx_byte_s;
            end
            if (byte_done_s && (state_r == CTRL)) begin
                bsb_r      <= BSB_W'(rx_byte_s[7:3]);
                rwb_r      <= rx_byte_s[2];
                om_r       <= rx_byte_s[1:0];
                byte_cnt_r <= 3'd0;
            end
            if (byte_done_s && (state_r == DATA) && (byte_cnt_r < 3'd4)) begin
                byte_cnt_r <= byte_cnt_r + 3'd1;
            end
            if (wr_fire_s) begin
                reg_wr_r <= 1'b1;
                wdata_r  <= rx_byte_s;
            end
            // Write address advances the cycle after the strobe
            if (reg_wr_r) begin
                addr_r <= addr_r + ADDR_ONE;
            end
            // Read prefetch: bump address now, request one cycle later
            if (rd_next_s) begin
                addr_r    <= addr_r + ADDR_ONE;
                rd_pend_r <= 1'b1;
            end
            if (rd_first_s) begin
                reg_rd_r <= 1'b1;
            end
            if (reg_rd_r && (state_r == DATA)) begin
                tx_sr_r <= reg_rdata;
                dout_r  <= reg_rdata[7];
            end
            if (ld_echo_s) begin
                tx_sr_r <= echo_val_s;
                dout_r  <= echo_val_s[7];
            end
            if (cs_rise_s) begin
                bit_cnt_r <= 3'd0;
                tx_sr_r   <= 8'h00;
                dout_r    <= 1'b0;
            end
        end
    end

    assign dout         = dout_r;
    assign reg_addr     = addr_r;
    assign reg_bsb      = bsb_r;
    assign reg_wr       = reg_wr_r;
    assign reg_wdata    = wdata_r;
    assign reg_rd       = reg_rd_r;
    assign frame_active = frame_active_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_w5500_spi_slave.sv
// Self-checking bench for w5500_spi_slave: directed table of frames, hand
// sequences for abort / coincident edge / mid-frame reset, and random frames
// checked against a frame-level reference model.
module tb_w5500_spi_slave;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cs = 1'b1;
    logic        sck = 1'b0;
    logic        din = 1'b0;
    logic        dout, reg_wr, reg_rd, frame_active, frame_err;
    logic [15:0] reg_addr;
    logic [4:0]  reg_bsb;
    logic [7:0]  reg_wdata, reg_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int half    = 8;
    int err_cnt = 0;

`ifdef W5500_PHASE_ECHO_EN
    localparam logic [23:0] EXP_HDR = 24'h010203;
`else
    localparam logic [23:0] EXP_HDR = 24'h000000;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];

    w5500_spi_slave dut (
        .clk          (clk),
        .rstn         (rstn),
        .cs           (cs),
        .sck          (sck),
        .din          (din),
        .dout         (dout),
        .reg_addr     (reg_addr),
        .reg_bsb      (reg_bsb),
        .reg_wr       (reg_wr),
        .reg_wdata    (reg_wdata),
        .reg_rd       (reg_rd),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Register file contents: a fixed function of the address
    function automatic logic [7:0] rd_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign reg_rdata = rd_fn(reg_addr);

    always @(negedge clk) begin
        if (reg_wr) wr_q.push_back(wr_t'({reg_addr, reg_wdata}));
        if (reg_rd) rd_q.push_back(reg_addr);
        if (frame_err) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            din = tx[i];
            wait_clk(half);
            sck = 1'b1;
            rx[i] = dout;
            wait_clk(half);
            sck = 1'b0;
        end
    endtask

    task automatic start_frame(input logic [15:0] a, input logic [7:0] c, output logic [23:0] hdr);
        logic [7:0] rx;
        wr_q.delete();
        rd_q.delete();
        err_cnt = 0;
        cs = 1'b0;
        wait_clk(half);
        xfer_bits(a[15:8], 8, rx); hdr[23:16] = rx;
        xfer_bits(a[7:0], 8, rx);  hdr[15:8]  = rx;
        xfer_bits(c, 8, rx);       hdr[7:0]   = rx;
    endtask

    task automatic end_frame();
        wait_clk(half);
        cs = 1'b1;
        wait_clk(2 * half + 4);
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [7:0] c, input int nd,
                             input logic [63:0] d, output logic [23:0] hdr, output logic [63:0] miso);
        logic [7:0] rx;
        miso = 64'h0;
        start_frame(a, c, hdr);
        check("frame_active_hi", {63'd0, frame_active}, 64'd1);
        for (int i = 0; i < nd; i++) begin
            xfer_bits(d[63-8*i -: 8], 8, rx);
            miso[63-8*i -: 8] = rx;
        end
        end_frame();
    endtask

    // Frame-level reference: what a W5500 register port should have seen
    task automatic check_model(input logic [15:0] a, input logic [7:0] c, input int nd,
                               input logic [63:0] d, input logic [23:0] hdr, input logic [63:0] miso);
        int lim, nw, nr;
        logic [63:0] exp_miso;
        logic [15:0] ea;
        case (c[1:0])
            2'b00:   lim = nd;
            2'b01:   lim = 1;
            2'b10:   lim = 2;
            default: lim = 4;
        endcase
        exp_miso = 64'h0;
        check("hdr_miso", {40'd0, hdr}, {40'd0, EXP_HDR});
        if (c[2]) begin
            nw = (nd < lim) ? nd : lim;
            check("n_wr", 64'(wr_q.size()), 64'(nw));
            check("n_rd", 64'(rd_q.size()), 64'd0);
            for (int i = 0; i < nw; i++) begin
                ea = a + 16'(i);
                if (i < wr_q.size()) check("wr_entry", {40'd0, wr_q[i]}, {40'd0, ea, d[63-8*i -: 8]});
            end
        end else begin
            nr = (c[1:0] == 2'b00) ? nd + 1 : ((nd + 1 < lim) ? nd + 1 : lim);
            check("n_rd", 64'(rd_q.size()), 64'(nr));
            check("n_wr", 64'(wr_q.size()), 64'd0);
            for (int i = 0; i < nr; i++) begin
                ea = a + 16'(i);
                if (i < rd_q.size()) check("rd_addr", {48'd0, rd_q[i]}, {48'd0, ea});
            end
            for (int i = 0; i < nd; i++) begin
                ea = a + 16'(i);
                if (c[1:0] == 2'b00 || i < lim) exp_miso[63-8*i -: 8] = rd_fn(ea);
            end
        end
        check("data_miso", miso, exp_miso);
        check("no_err", 64'(err_cnt), 64'd0);
        check("bsb", {59'd0, reg_bsb}, {59'd0, c[7:3]});
        check("idle_after", {63'd0, frame_active}, 64'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  ctrl;
        int          nd;
        logic [63:0] data;
        logic [63:0] exp_miso;
        int          exp_nwr;
        int          exp_nrd;
    } vec_t;

    vec_t        vecs[6];
    logic [23:0] hdr;
    logic [63:0] miso;
    logic [7:0]  rx;
    logic [15:0] ra;
    logic [7:0]  rc;
    int          rnd;
    logic [63:0] rdat;

    initial begin
        vecs[0] = '{16'h002E, 8'h04, 2, 64'h0100_0000_0000_0000, 64'h0, 2, 0};
        vecs[1] = '{16'h0039, 8'h09, 2, 64'h0, 64'h3900_0000_0000_0000, 0, 1};
        vecs[2] = '{16'h0010, 8'h03, 4, 64'h0, 64'h1011_1213_0000_0000, 0, 4};
        vecs[3] = '{16'hFFFF, 8'h04, 2, 64'hAABB_0000_0000_0000, 64'h0, 2, 0};
        vecs[4] = '{16'h0100, 8'h0E, 3, 64'h1122_3300_0000_0000, 64'h0, 2, 0};
        vecs[5] = '{16'h1234, 8'h10, 2, 64'h0, 64'h2627_0000_0000_0000, 0, 3};

        // Reset values
        wait_clk(3);
        check("reset_outputs", {36'd0, dout, reg_addr, reg_bsb, reg_wr, reg_wdata, reg_rd, frame_active, frame_err},
              64'd0);
        rstn = 1'b1;
        wait_clk(4);

        // Directed table
        foreach (vecs[k]) begin
            run_frame(vecs[k].addr, vecs[k].ctrl, vecs[k].nd, vecs[k].data, hdr, miso);
            check("tbl_miso", miso, vecs[k].exp_miso);
            check("tbl_nwr", 64'(wr_q.size()), 64'(vecs[k].exp_nwr));
            check("tbl_nrd", 64'(rd_q.size()), 64'(vecs[k].exp_nrd));
            check_model(vecs[k].addr, vecs[k].ctrl, vecs[k].nd, vecs[k].data, hdr, miso);
        end

        // Abort after 12 address bits, then a clean frame
        wr_q.delete(); rd_q.delete(); err_cnt = 0;
        cs = 1'b0;
        wait_clk(half);
        xfer_bits(8'h12, 8, rx);
        xfer_bits(8'h34, 4, rx);
        end_frame();
        check("abort_err", 64'(err_cnt), 64'd1);
        check("abort_nwr", 64'(wr_q.size()), 64'd0);
        check("abort_nrd", 64'(rd_q.size()), 64'd0);
        check("abort_idle", {63'd0, frame_active}, 64'd0);
        run_frame(vecs[0].addr, vecs[0].ctrl, vecs[0].nd, vecs[0].data, hdr, miso);
        check_model(vecs[0].addr, vecs[0].ctrl, vecs[0].nd, vecs[0].data, hdr, miso);

        // Rising sck and cs rise in the same cycle: the bit is dropped
        start_frame(16'h0200, 8'h04, hdr);
        xfer_bits(8'h77, 8, rx);
        xfer_bits(8'h88, 7, rx);
        din = 1'b0;
        wait_clk(half);
        sck = 1'b1;
        cs  = 1'b1;
        wait_clk(half);
        sck = 1'b0;
        wait_clk(2 * half + 4);
        check("coinc_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) check("coinc_wr", {40'd0, wr_q[0]}, {40'd0, 16'h0200, 8'h77});
        check("coinc_err", 64'(err_cnt), 64'd1);

        // Reset in the middle of a data byte
        start_frame(16'h5A5A, 8'h1C, hdr);
        xfer_bits(8'hC3, 4, rx);
        check("pre_rst_active", {63'd0, frame_active}, 64'd1);
        check("pre_rst_addr", {48'd0, reg_addr}, {48'd0, 16'h5A5A});
        #2 rstn = 1'b0;
        #1 check("rst_outputs", {36'd0, dout, reg_addr, reg_bsb, reg_wr, reg_wdata, reg_rd, frame_active, frame_err},
                 64'd0);
        sck = 1'b0;
        cs  = 1'b1;
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(4);
        run_frame(vecs[2].addr, vecs[2].ctrl, vecs[2].nd, vecs[2].data, hdr, miso);
        check_model(vecs[2].addr, vecs[2].ctrl, vecs[2].nd, vecs[2].data, hdr, miso);

        // Random frames against the reference model
        for (int r = 0; r < 16; r++) begin
            ra   = 16'($urandom);
            rc   = 8'($urandom);
            rnd  = int'($urandom_range(0, 5));
            rdat = {32'($urandom), 32'($urandom)};
            half = int'($urandom_range(6, 10));
            run_frame(ra, rc, rnd, rdat, hdr, miso);
            check_model(ra, rc, rnd, rdat, hdr, miso);
        end
        half = 8;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
